// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: merges ALU and load results onto one write port
// and can sweep zeros into registers 1..NUM_REGS-1.
//   state | meaning
//   ARB   | arbitrate ALU/MEM writebacks, MEM favoured unless ALU has waited twice
//   CLEAR | write zero to one register per cycle; both requesters held off
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_REGS      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDRESS_WIDTH-1:0] alu_dest,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  output logic                     alu_ready,
  input  logic                     mem_valid,
  input  logic [ADDRESS_WIDTH-1:0] mem_dest,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic                     mem_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic                     RegWrite,
  output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
  output logic [DATA_WIDTH-1:0]    rg_wrt_data,
  output logic                     wb_src
);

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_IDX = ADDRESS_WIDTH'(NUM_REGS - 1);

  state_t                   state, state_next;
  logic [ADDRESS_WIDTH-1:0] idx;
  logic [1:0]               starve;
  logic                     alu_win, mem_win, sweep_done;

  assign sweep_done = (idx == LAST_IDX);
  assign alu_ready  = alu_win;
  assign mem_ready  = mem_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    alu_win    = 1'b0;
    mem_win    = 1'b0;
    clr_busy   = 1'b0;
    case (state)
      ARB: begin
        // A clear request blocks both grants in the cycle it is raised.
        if (clr_start)
          state_next = CLEAR;
        else if (mem_valid && !(alu_valid && starve == 2'd2))
          mem_win = 1'b1;
        else if (alu_valid)
          alu_win = 1'b1;
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if (sweep_done) state_next = ARB;
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      starve      <= 2'd0;
      RegWrite    <= 1'b0;
      rg_wrt_dest <= '0;
      rg_wrt_data <= '0;
      wb_src      <= 1'b0;
    end else begin
      if (alu_valid && !alu_win)
        starve <= (starve == 2'd2) ? 2'd2 : starve + 2'd1;
      else
        starve <= 2'd0;

      RegWrite <= 1'b0;
      if (state == CLEAR) begin
        RegWrite    <= 1'b1;
        rg_wrt_dest <= idx;
        rg_wrt_data <= '0;
        wb_src      <= 1'b0;
        idx         <= sweep_done ? '0 : idx + ADDRESS_WIDTH'(1);
      end else if (alu_win) begin
        // Writes to register 0 complete the handshake but never strobe the file.
        RegWrite    <= (alu_dest != '0);
        rg_wrt_dest <= alu_dest;
        rg_wrt_data <= alu_data;
        wb_src      <= 1'b0;
      end else if (mem_win) begin
        RegWrite    <= (mem_dest != '0);
        rg_wrt_dest <= mem_dest;
        rg_wrt_data <= mem_data;
        wb_src      <= 1'b1;
      end else if (clr_start) begin
        idx <= ADDRESS_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: fixed vectors, clear/reset sequences, then
// random traffic against a spec-level model.
module tb_regfile_wb_arbiter;

  localparam int NREGS = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, clr_start = 1'b0;
  logic [4:0]  alu_dest = '0, mem_dest = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic        alu_ready, mem_ready, clr_busy, RegWrite, wb_src;
  logic [4:0]  rg_wrt_dest;
  logic [31:0] rg_wrt_data;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_REGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .RegWrite(RegWrite), .rg_wrt_dest(rg_wrt_dest), .rg_wrt_data(rg_wrt_data), .wb_src(wb_src)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_clear;
  int          m_idx, m_starve;
  bit          m_we, m_src;
  logic [4:0]  m_dest;
  logic [31:0] m_data;
  bit          m_ar, m_mr, m_busy;

  // Sampled DUT values
  logic        s_ar, s_mr, s_busy, s_we, s_src;
  logic [4:0]  s_dest;
  logic [31:0] s_data;

  typedef struct {
    logic av; logic [4:0] ad; logic [31:0] adat;
    logic mv; logic [4:0] md; logic [31:0] mdat;
    logic cs;
    logic e_ar, e_mr, e_we; logic [4:0] e_dest; logic [31:0] e_data; logic e_src;
  } vec_t;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  function automatic void model_reset();
    m_clear = 0; m_idx = 0; m_starve = 0;
    m_we = 0; m_src = 0; m_dest = '0; m_data = '0;
  endfunction

  function automatic void model_grants();
    m_ar = 0; m_mr = 0;
    m_busy = m_clear;
    if (!m_clear && !clr_start) begin
      if (alu_valid && mem_valid) begin
        if (m_starve >= 2) m_ar = 1; else m_mr = 1;
      end else begin
        m_ar = alu_valid; m_mr = mem_valid;
      end
    end
  endfunction

  function automatic void model_edge();
    if (m_clear) begin
      m_we = 1; m_dest = 5'(m_idx); m_data = '0; m_src = 0;
      if (m_idx == NREGS - 1) m_clear = 0;
      else m_idx++;
    end else begin
      m_we = 0;
      if (m_ar) begin
        m_we = (alu_dest != 0); m_dest = alu_dest; m_data = alu_data; m_src = 0;
      end else if (m_mr) begin
        m_we = (mem_dest != 0); m_dest = mem_dest; m_data = mem_data; m_src = 1;
      end
      if (clr_start) begin m_clear = 1; m_idx = 1; end
    end
    if (alu_valid && !m_ar) m_starve = (m_starve >= 2) ? 2 : m_starve + 1;
    else m_starve = 0;
  endfunction

  // Called at a negedge: drive, sample combinational outputs, clock, sample registers.
  task automatic step(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                      input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                      input logic cs);
    alu_valid = av; alu_dest = ad; alu_data = adat;
    mem_valid = mv; mem_dest = md; mem_data = mdat;
    clr_start = cs;
    #2;
    s_ar = alu_ready; s_mr = mem_ready; s_busy = clr_busy;
    model_grants();
    @(posedge clk);
    model_edge();
    #1;
    s_we = RegWrite; s_dest = rg_wrt_dest; s_data = rg_wrt_data; s_src = wb_src;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t vecs[9];
  bit   found;

  initial begin
    model_reset();
    // Reset state
    #3;
    check("rst_regwrite", RegWrite, 0);
    check("rst_dest", rg_wrt_dest, 0);
    check("rst_data", rg_wrt_data, 0);
    check("rst_src", wb_src, 0);
    check("rst_busy", clr_busy, 0);
    @(negedge clk);
    rst = 1'b1;

    vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0,   1, 0, 1, 5, 32'hDEADBEEF, 0};
    vecs[1] = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 5, 32'hDEADBEEF, 0};
    vecs[2] = '{0, 0, 0, 1, 0, 32'h1234, 0,       0, 1, 0, 0, 32'h1234, 1};
    vecs[3] = '{1, 3, 32'hA, 1, 7, 32'hB, 0,      0, 1, 1, 7, 32'hB, 1};
    vecs[4] = '{1, 3, 32'hA, 1, 7, 32'hB, 0,      0, 1, 1, 7, 32'hB, 1};
    vecs[5] = '{1, 3, 32'hA, 1, 7, 32'hB, 0,      1, 0, 1, 3, 32'hA, 0};
    vecs[6] = '{1, 3, 32'hA, 1, 7, 32'hB, 0,      0, 1, 1, 7, 32'hB, 1};
    vecs[7] = '{1, 9, 32'h99, 0, 0, 0, 0,         1, 0, 1, 9, 32'h99, 0};
    vecs[8] = '{1, 4, 32'h44, 0, 0, 0, 1,         0, 0, 0, 9, 32'h99, 0};

    foreach (vecs[i]) begin
      step(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].mv, vecs[i].md, vecs[i].mdat, vecs[i].cs);
      check($sformatf("v%0d_alu_ready", i), s_ar, vecs[i].e_ar);
      check($sformatf("v%0d_mem_ready", i), s_mr, vecs[i].e_mr);
      check($sformatf("v%0d_busy", i), s_busy, 0);
      check($sformatf("v%0d_regwrite", i), s_we, vecs[i].e_we);
      check($sformatf("v%0d_dest", i), s_dest, vecs[i].e_dest);
      check($sformatf("v%0d_data", i), s_data, vecs[i].e_data);
      check($sformatf("v%0d_src", i), s_src, vecs[i].e_src);
    end

    // Clear sweep with ALU waiting; a second clr_start mid-sweep is ignored.
    for (int k = 1; k < NREGS; k++) begin
      step(1, 4, 32'h44, 0, 0, 0, (k == 5) ? 1'b1 : 1'b0);
      check($sformatf("clr%0d_busy", k), s_busy, 1);
      check($sformatf("clr%0d_alu_ready", k), s_ar, 0);
      check($sformatf("clr%0d_regwrite", k), s_we, 1);
      check($sformatf("clr%0d_dest", k), s_dest, k);
      check($sformatf("clr%0d_data", k), s_data, 0);
      check($sformatf("clr%0d_src", k), s_src, 0);
    end
    step(1, 4, 32'h44, 0, 0, 0, 0);
    check("post_clr_busy", s_busy, 0);
    check("post_clr_alu_ready", s_ar, 1);
    check("post_clr_regwrite", s_we, 1);
    check("post_clr_dest", s_dest, 4);
    check("post_clr_data", s_data, 32'h44);
    idle();
    check("post_clr_idle_regwrite", s_we, 0);

    // Reset in the middle of a sweep, asserted between edges.
    step(0, 0, 0, 0, 0, 0, 1);
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      idle();
      if (s_we === 1'b1 && s_dest === 5'd10) found = 1;
    end
    check("reach_dest10", found, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_regwrite", RegWrite, 0);
    check("midrst_dest", rg_wrt_dest, 0);
    check("midrst_data", rg_wrt_data, 0);
    check("midrst_src", wb_src, 0);
    check("midrst_busy", clr_busy, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      idle();
      check($sformatf("after_rst%0d_busy", k), s_busy, 0);
      check($sformatf("after_rst%0d_regwrite", k), s_we, 0);
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0);
      check("rnd_alu_ready", s_ar, m_ar);
      check("rnd_mem_ready", s_mr, m_mr);
      check("rnd_busy", s_busy, m_busy);
      check("rnd_regwrite", s_we, m_we);
      check("rnd_dest", s_dest, m_dest);
      check("rnd_data", s_data, m_data);
      check("rnd_src", s_src, m_src);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of each register and write data.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, default 32, number of registers to sweep during clear.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low; rst=0 resets immediately regardless of clk.
REQ-006 SHALL have ports alu_valid  input  1, alu_dest  input  ADDRESS_WIDTH, alu_data  input  DATA_WIDTH: ALU writeback request.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted this cycle when alu_valid=1.
REQ-008 SHALL have ports mem_valid  input  1, mem_dest  input  ADDRESS_WIDTH, mem_data  input  DATA_WIDTH: load writeback request.
REQ-009 SHALL have port mem_ready  output  1  load request accepted this cycle when mem_valid=1.
REQ-010 SHALL have port clr_start  input  1  one-cycle request to zero all registers.
REQ-011 SHALL have port clr_busy  output  1  clear sweep in progress.
REQ-012 SHALL have ports RegWrite  output  1, rg_wrt_dest  output  ADDRESS_WIDTH, rg_wrt_data  output  DATA_WIDTH: register file write port drive.
REQ-013 SHALL have port wb_src  output  1  source of current write: 0=ALU, 1=MEM.

Function
REQ-014 SHALL implement FSM states ARB and CLEAR; reset state ARB.
REQ-015 alu_ready and mem_ready SHALL be combinational, both 0 in CLEAR and in any cycle where clr_start=1.
REQ-016 In ARB, at most one ready SHALL be 1 per cycle; handshake = valid & ready.
REQ-017 Priority in ARB: MEM wins over ALU, except when starve counter = 2, then ALU wins.
REQ-018 Starve counter (2 bits) SHALL increment, saturating at 2, each cycle alu_valid=1 and ALU not granted; SHALL clear on ALU handshake or alu_valid=0.
REQ-019 Single requester valid SHALL be granted the same cycle (no idle bubble).
REQ-020 Handshake in cycle N SHALL produce RegWrite=1 in cycle N+1 with registered dest/data and wb_src of the winner.
REQ-021 Handshake with dest=0 SHALL complete (ready=1) but RegWrite SHALL stay 0 in N+1; rg_wrt_dest/rg_wrt_data still update.
REQ-022 No handshake in cycle N SHALL give RegWrite=0 in N+1; rg_wrt_dest, rg_wrt_data, wb_src hold previous values.
REQ-023 clr_start=1 in ARB SHALL move to CLEAR next cycle with sweep index=1; any pending RegWrite from a cycle N-1 handshake still issues.
REQ-024 In CLEAR each cycle: RegWrite=1, rg_wrt_dest=index, rg_wrt_data=0, wb_src=0 (registered, appearing cycle after index update), index+1.
REQ-025 After writing index NUM_REGS-1 the FSM SHALL return to ARB; sweep = NUM_REGS-1 writes, register 0 never written.
REQ-026 clr_busy SHALL be 1 exactly while state=CLEAR; clr_start during CLEAR SHALL be ignored.
REQ-027 Sweep index SHALL be ADDRESS_WIDTH bits, compare against NUM_REGS-1, no wrap.

Reset
REQ-028 rst=0 SHALL asynchronously force: state ARB, index 0, starve counter 0, RegWrite 0, rg_wrt_dest 0, rg_wrt_data 0, wb_src 0, clr_busy 0.
REQ-029 rst=0 during CLEAR SHALL abort the sweep; no resume after release.
REQ-030 First handshake SHALL be possible in the first rising edge with rst=1.

Verification
REQ-031 Reset: rst=0 mid-cycle with RegWrite=1 -> RegWrite, rg_wrt_dest, rg_wrt_data, wb_src all 0 before next edge.
REQ-032 Single ALU: alu_valid=1, dest=5, data=0xDEADBEEF -> alu_ready=1 same cycle; next cycle RegWrite=1, dest=5, data=0xDEADBEEF, wb_src=0.
REQ-033 Contention: alu_valid and mem_valid held 1 for 4 cycles -> grants MEM, MEM, ALU, MEM; starve counter cleared after ALU grant.
REQ-034 x0 write: mem_valid=1, dest=0 -> mem_ready=1; next cycle RegWrite=0, wb_src=1.
REQ-035 Clear: clr_start pulse with alu_valid=1 same cycle -> alu_ready=0; clr_busy=1 for 31 cycles; RegWrite=1 with dest 1..31, data 0; then ARB, alu granted.
REQ-036 Reset mid-clear: rst=0 at sweep dest=10 -> clr_busy=0, RegWrite=0; after release, no further clear writes.
